// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered MicroUAZ instruction decoder with a valid/ready
// handshake, flag-based jump resolution, flush, and a two-word LOADW
// instruction that carries a full NW-bit immediate in its second word.
module instr_decode_stage #(
    parameter int RW = 3,
    parameter int NW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3+2*RW-1:0]     instr,
    input  logic                  flag_z,
    input  logic                  flag_c,
    input  logic                  flag_n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  move,
    output logic                  write,
    output logic                  math,
    output logic                  sel_out,
    output logic [RW-1:0]         j,
    output logic [RW-1:0]         k,
    output logic [RW-1:0]         i,
    output logic [NW-1:0]         n,
    output logic [1:0]            sel_pc,
    output logic [2:0]            f
);

    localparam int IW = 3 + 2*RW;

    localparam logic [2:0] OP_LOADI  = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STOREI = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_MOVE   = 3'b100;
    localparam logic [2:0] OP_MATH   = 3'b101;
    localparam logic [2:0] OP_JUMP   = 3'b110;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b01;
    localparam logic [1:0] PC_LINK = 2'b10;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_IMM
    } state_t;

    state_t state_q, state_d;

    // Instruction fields
    logic [2:0]    op;
    logic [RW-1:0] fa;
    logic [RW-1:0] fb;

    assign op = instr[2:0];
    assign fa = instr[RW+2:3];
    assign fb = instr[IW-1:RW+3];

    // Handshake: a new word can enter only if the output slot is free or
    // draining this cycle; flush blocks the accept outright.
    logic accept;
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Resolve a jump condition against the flags seen in the accept cycle.
    function automatic logic [1:0] jump_sel(input logic [2:0] cond,
                                            input logic       fz,
                                            input logic       fc,
                                            input logic       fneg);
        logic taken;
        taken = 1'b0;
        case (cond)
            3'd0:    return PC_JUMP;
            3'd1:    return PC_LINK;
            3'd2:    taken = fz;
            3'd3:    taken = !fz;
            3'd4:    taken = fc;
            3'd5:    taken = !fc;
            3'd6:    taken = fneg;
            default: taken = !fneg;
        endcase
        return taken ? PC_JUMP : PC_NEXT;
    endfunction

    // Stage 0: combinational decode of the presented word
    logic          move_p0, write_p0, math_p0, sel_out_p0;
    logic [RW-1:0] j_p0, k_p0, i_p0;
    logic [NW-1:0] n_p0;
    logic [1:0]    sel_pc_p0;
    logic [2:0]    f_p0;
    logic          produce_p0;
    logic          loadw_first_p0;
    logic [RW-1:0] a_lat_q;

    // Decode opcode (or raw immediate in WAIT_IMM) into the next control set.
    always_comb begin
        move_p0        = 1'b0;
        write_p0       = 1'b0;
        math_p0        = 1'b0;
        sel_out_p0     = 1'b0;
        j_p0           = '0;
        k_p0           = '0;
        i_p0           = '0;
        n_p0           = '0;
        sel_pc_p0      = PC_NEXT;
        f_p0           = '0;
        produce_p0     = 1'b0;
        loadw_first_p0 = 1'b0;
        if (state_q == WAIT_IMM) begin
            produce_p0 = 1'b1;
            k_p0       = a_lat_q;
            n_p0       = instr[NW-1:0];
            sel_out_p0 = 1'b1;
        end else begin
            produce_p0 = 1'b1;
            case (op)
                OP_LOADI: begin
                    k_p0 = fa;
                    j_p0 = fb;
                end
                OP_LOAD: begin
                    k_p0 = fa;
                    i_p0 = fb;
                end
                OP_STOREI: begin
                    k_p0     = fa;
                    j_p0     = fb;
                    write_p0 = 1'b1;
                end
                OP_STORE: begin
                    k_p0     = fa;
                    i_p0     = fb;
                    write_p0 = 1'b1;
                end
                OP_MOVE: begin
                    k_p0    = fa;
                    i_p0    = fb;
                    move_p0 = 1'b1;
                end
                OP_MATH: begin
                    k_p0    = fa;
                    f_p0    = fb[2:0];
                    math_p0 = 1'b1;
                end
                OP_JUMP: begin
                    k_p0      = fa;
                    f_p0      = fb[2:0];
                    sel_pc_p0 = jump_sel(fb[2:0], flag_z, flag_c, flag_n);
                end
                default: begin
                    // B==1 opens a LOADW; anything else is a NOP bubble
                    if (fb == RW'(1)) begin
                        produce_p0     = 1'b0;
                        loadw_first_p0 = 1'b1;
                    end
                end
            endcase
        end
    end

    // Next-state logic for the LOADW sequencer; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            if (state_q == WAIT_IMM) begin
                state_d = IDLE;
            end else if (loadw_first_p0) begin
                state_d = WAIT_IMM;
            end
        end
    end

    // State register and latched destination of a pending LOADW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_lat_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && loadw_first_p0) begin
                a_lat_q <= fa;
            end
        end
    end

    // Stage 1: registered controls
    logic          vld_p1;
    logic          move_p1, write_p1, math_p1, sel_out_p1;
    logic [RW-1:0] j_p1, k_p1, i_p1;
    logic [NW-1:0] n_p1;
    logic [1:0]    sel_pc_p1;
    logic [2:0]    f_p1;

    // Output valid: set by an output-producing accept, cleared by handshake or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= produce_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Output controls load only when a new output is produced; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_p1    <= 1'b0;
            write_p1   <= 1'b0;
            math_p1    <= 1'b0;
            sel_out_p1 <= 1'b0;
            j_p1       <= '0;
            k_p1       <= '0;
            i_p1       <= '0;
            n_p1       <= '0;
            sel_pc_p1  <= PC_NEXT;
            f_p1       <= '0;
        end else if (accept && produce_p0) begin
            move_p1    <= move_p0;
            write_p1   <= write_p0;
            math_p1    <= math_p0;
            sel_out_p1 <= sel_out_p0;
            j_p1       <= j_p0;
            k_p1       <= k_p0;
            i_p1       <= i_p0;
            n_p1       <= n_p0;
            sel_pc_p1  <= sel_pc_p0;
            f_p1       <= f_p0;
        end
    end

    assign out_valid = vld_p1;
    assign move      = move_p1;
    assign write     = write_p1;
    assign math      = math_p1;
    assign sel_out   = sel_out_p1;
    assign j         = j_p1;
    assign k         = k_p1;
    assign i         = i_p1;
    assign n         = n_p1;
    assign sel_pc    = sel_pc_p1;
    assign f         = f_p1;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed testbench for instr_decode_stage (RW=3, NW=8).
module tb_instr_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] instr;
    logic       flag_z, flag_c, flag_n;
    logic       out_valid;
    logic       out_ready;
    logic       move, write, math, sel_out;
    logic [2:0] j, k, i;
    logic [7:0] n;
    logic [1:0] sel_pc;
    logic [2:0] f;

    int checks = 0;
    int errors = 0;

    // Packed view of all controls: {move,write,math,sel_out,j,k,i,n,sel_pc,f}
    logic [25:0] ctl;
    assign ctl = {move, write, math, sel_out, j, k, i, n, sel_pc, f};

    instr_decode_stage #(.RW(3), .NW(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .move(move), .write(write), .math(math), .sel_out(sel_out),
        .j(j), .k(k), .i(i), .n(n), .sel_pc(sel_pc), .f(f)
    );

    always #5 clk = ~clk;

    // Present one word for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic [8:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (ctl !== 26'd0) begin
            errors++; $display("FAIL reset_ctl: got %h want 0", ctl);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loadi();
        send(9'h150);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL loadi_valid: got %b want 1", out_valid);
        end
        checks++;
        if (ctl !== {4'b0000, 3'd5, 3'd2, 3'd0, 8'h00, 2'b00, 3'd0}) begin
            errors++; $display("FAIL loadi_ctl: got %h want %h", ctl,
                               {4'b0000, 3'd5, 3'd2, 3'd0, 8'h00, 2'b00, 3'd0});
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL loadi_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_jump();
        flag_z = 1'b1;
        send(9'h09E);
        checks++;
        if (out_valid !== 1'b1 || ctl !== {4'b0000, 3'd0, 3'd3, 3'd0, 8'h00, 2'b01, 3'd2}) begin
            errors++; $display("FAIL jump_z_taken: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl,
                               {4'b0000, 3'd0, 3'd3, 3'd0, 8'h00, 2'b01, 3'd2});
        end
        flag_z = 1'b0;
        send(9'h09E);
        checks++;
        if (sel_pc !== 2'b00 || f !== 3'd2 || k !== 3'd3) begin
            errors++; $display("FAIL jump_z_not_taken: got sel_pc=%b f=%0d k=%0d want 00 2 3", sel_pc, f, k);
        end
        send(9'h05E);
        checks++;
        if (sel_pc !== 2'b10 || f !== 3'd1 || k !== 3'd3) begin
            errors++; $display("FAIL jump_link: got sel_pc=%b f=%0d k=%0d want 10 1 3", sel_pc, f, k);
        end
        send(9'h0DE);
        checks++;
        if (sel_pc !== 2'b01) begin
            errors++; $display("FAIL jump_nz: got sel_pc=%b want 01", sel_pc);
        end
        flag_c = 1'b1;
        send(9'h11E);
        checks++;
        if (sel_pc !== 2'b01 || f !== 3'd4) begin
            errors++; $display("FAIL jump_c_taken: got sel_pc=%b f=%0d want 01 4", sel_pc, f);
        end
        flag_c = 1'b0;
        send(9'h11E);
        checks++;
        if (sel_pc !== 2'b00) begin
            errors++; $display("FAIL jump_c_not_taken: got sel_pc=%b want 00", sel_pc);
        end
        idle_cycle();
    endtask

    task automatic test_loadw();
        send(9'h067);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL loadw_first_no_output: got %b want 0", out_valid);
        end
        send(9'h0A5);
        checks++;
        if (out_valid !== 1'b1 || ctl !== {4'b0001, 3'd0, 3'd4, 3'd0, 8'hA5, 2'b00, 3'd0}) begin
            errors++; $display("FAIL loadw_imm: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl,
                               {4'b0001, 3'd0, 3'd4, 3'd0, 8'hA5, 2'b00, 3'd0});
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL loadw_single_output: got %b want 0", out_valid);
        end
        // Back in IDLE: a NOP (op 111, B!=1) produces an all-zero valid slot
        send(9'h007);
        checks++;
        if (out_valid !== 1'b1 || ctl !== 26'd0) begin
            errors++; $display("FAIL nop_bubble: got v=%b ctl=%h want v=1 ctl=0", out_valid, ctl);
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        logic [25:0] exp_ctl;
        exp_ctl = {4'b0010, 3'd0, 3'd1, 3'd0, 8'h00, 2'b00, 3'd6};
        @(negedge clk);
        out_ready = 1'b0;
        send(9'h18D);
        checks++;
        if (out_valid !== 1'b1 || ctl !== exp_ctl) begin
            errors++; $display("FAIL bp_math: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl, exp_ctl);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            instr    = 9'h150;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || ctl !== exp_ctl) begin
                errors++; $display("FAIL bp_hold cycle %0d: got v=%b ctl=%h want v=1 ctl=%h",
                                   c, out_valid, ctl, exp_ctl);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        send(9'h150);
        checks++;
        if (k !== 3'd2 || j !== 3'd5 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got v=%b k=%0d j=%0d want 1 2 5", out_valid, k, j);
        end
        send(9'h18D);
        checks++;
        if (math !== 1'b1 || k !== 3'd1 || f !== 3'd6 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got v=%b math=%b k=%0d f=%0d want 1 1 1 6",
                               out_valid, math, k, f);
        end
        send(9'h0E4);  // MOVE R4 <- R3
        checks++;
        if (ctl !== {4'b1000, 3'd0, 3'd4, 3'd3, 8'h00, 2'b00, 3'd0} || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_move: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl,
                               {4'b1000, 3'd0, 3'd4, 3'd3, 8'h00, 2'b00, 3'd0});
        end
        send(9'h0D3);  // STORE R2 -> [R3]
        checks++;
        if (ctl !== {4'b0100, 3'd0, 3'd2, 3'd3, 8'h00, 2'b00, 3'd0}) begin
            errors++; $display("FAIL b2b_store: got ctl=%h want %h", ctl,
                               {4'b0100, 3'd0, 3'd2, 3'd3, 8'h00, 2'b00, 3'd0});
        end
        idle_cycle();
    endtask

    task automatic test_flush();
        send(9'h067);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = 9'h0A5;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_accept: got %b want 0", out_valid);
        end
        send(9'h150);
        checks++;
        if (out_valid !== 1'b1 || ctl !== {4'b0000, 3'd5, 3'd2, 3'd0, 8'h00, 2'b00, 3'd0}) begin
            errors++; $display("FAIL flush_then_loadi: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl,
                               {4'b0000, 3'd5, 3'd2, 3'd0, 8'h00, 2'b00, 3'd0});
        end
        // Flush also drops a stalled output
        @(negedge clk);
        out_ready = 1'b0;
        flush     = 1'b1;
        idle_cycle();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_drop_output: got %b want 0", out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        send(9'h18D);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ctl !== 26'd0) begin
            errors++; $display("FAIL reset_mid_valid: got v=%b ctl=%h want v=0 ctl=0", out_valid, ctl);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(9'h067);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ctl !== 26'd0) begin
            errors++; $display("FAIL reset_mid_wait_imm: got v=%b ctl=%h want v=0 ctl=0", out_valid, ctl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(9'h18D);
        checks++;
        if (out_valid !== 1'b1 || ctl !== {4'b0010, 3'd0, 3'd1, 3'd0, 8'h00, 2'b00, 3'd6}) begin
            errors++; $display("FAIL reset_mid_decode: got v=%b ctl=%h want v=1 ctl=%h", out_valid, ctl,
                               {4'b0010, 3'd0, 3'd1, 3'd0, 8'h00, 2'b00, 3'd6});
        end
        idle_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        flag_z    = 1'b0;
        flag_c    = 1'b0;
        flag_n    = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_loadi();
        test_jump();
        test_loadw();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, parametrised instruction-decode pipeline stage for the MicroUAZ core, sitting between instruction fetch and the register file/ALU/PC-select logic. It decodes opcode plus two register/immediate fields into the same control set as the combinational decoder: move, write, j, k, i, math, sel_out, n, sel_pc and f. It adds valid/ready handshaking, flag-based jump resolution, a flush, and a two-word LOADW instruction that carries a full NW-bit immediate.

## Interface
Parameters:
- RW, 3, register-index / field width; instruction width IW = 3 + 2*RW (local).
- NW, 8, immediate (n) width; constraint NW <= IW.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  drop output and pending LOADW.
- in_valid  in  1  instr valid.
- in_ready  out  1  stage can accept instr.
- instr  in  IW  fields: op=[2:0], A=[RW+2:3], B=[IW-1:RW+3].
- flag_z, flag_c, flag_n  in  1 each  ALU flags, sampled on jump accept.
- out_valid  out  1  decoded controls valid.
- out_ready  in  1  downstream accepts.
- move, write, math, sel_out  out  1 each.
- j, k, i  out  RW each.
- n  out  NW.
- sel_pc  out  2  00 PC+1, 01 jump to Rk, 10 jump-and-link (PC saved in R7).
- f  out  3  ALU op / jump condition.

## Operation
- Accept = in_valid && in_ready. in_ready = (!out_valid || out_ready) && !flush.
- Decode on accept (all unlisted outputs 0):
  - 000 LOADI: k=A, j=B.
  - 001 LOAD: k=A, i=B.
  - 010 STOREI: k=A, j=B, write=1.
  - 011 STORE: k=A, i=B, write=1.
  - 100 MOVE: k=A, i=B, move=1.
  - 101 MATH: k=A, f=B[2:0], math=1.
  - 110 JUMP: k=A, f=B[2:0], sel_pc per condition below.
  - 111 with B==1: LOADW first word, no output produced; latch A, go to WAIT_IMM.
  - 111 otherwise: NOP, all outputs 0, out_valid still asserted (one bubble slot).
- Jump conditions (B[2:0]): 0 always→01; 1 always→10; 2 Z; 3 !Z; 4 C; 5 !C; 6 N; 7 !N. Taken→01, not taken→00. Flags are those present in the accept cycle.
- FSM: IDLE, WAIT_IMM.
  - IDLE→WAIT_IMM on accepted LOADW first word.
  - WAIT_IMM: next accepted word is raw data, no opcode decode. Outputs k=latched A, n=instr[NW-1:0], sel_out=1, all others 0. Return to IDLE.
  - flush in any state→IDLE.
- Output register updates only on accept of an output-producing word. Otherwise it holds while out_valid && !out_ready; out_valid clears on out_ready without a new output.
- LOADW first word accepted while output drains: out_valid falls on handshake, no new output.

## Timing
- Reset (async assert, sync-released usage): state=IDLE, out_valid=0, every control output 0 (move, write, math, sel_out, j, k, i, n, sel_pc, f).
- Latency: 1 cycle from accept to out_valid (2 words → 1 output for LOADW, out_valid 1 cycle after second word).
- Throughput: 1 instr/cycle with out_ready held high.
- Back-pressure: outputs stable, bit-exact, while out_valid && !out_ready.
- flush: next edge out_valid=0, state=IDLE, latched A discarded; no accept in a flush cycle (flush beats in_valid).
- Reset mid-LOADW: returns to IDLE; next word decodes as an opcode.

## Test plan
- LOADI R2 #5, instr=9'h150, out_ready=1 -> next cycle out_valid=1, k=2, j=5, all else 0.
- JUMP R3 cond Z, instr=9'h09E: flag_z=1 -> sel_pc=01, f=2, k=3; repeat with flag_z=0 -> sel_pc=00. Cond 1 (9'h05E) -> sel_pc=10.
- LOADW R4: 9'h067 then 9'h0A5 -> exactly one output: k=4, n=8'hA5, sel_out=1. No out_valid after the first word.
- MATH R1 op 6, 9'h18D, with out_ready=0 for 3 cycles -> math=1, k=1, f=6 held stable, in_ready=0. Then released: one handshake, out_valid drops.
- flush after 9'h067, then 9'h150 -> decoded as LOADI (k=2, j=5), not immediate. flush with in_valid=1 -> instr not accepted.
- rst_n low mid-stream (out_valid=1, WAIT_IMM) -> immediately all outputs 0, out_valid=0. After release, 9'h18D decodes normally.
